branch_sequencer: RTL and testbench

//  Program-counter sequencer for the CPU fetch stage. Holds PC and a flag register written by the ALU.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/cond_eval.sv | 28 ++
 rtl/branch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch condition codes, flag bit positions and sequencer states
// for branch_sequencer and cond_eval.
package branch_pkg;

    localparam logic [3:0] BR_Z    = 4'd0;
    localparam logic [3:0] BR_C    = 4'd1;
    localparam logic [3:0] BR_NZNC = 4'd2;
    localparam logic [3:0] BR_LT   = 4'd3;
    localparam logic [3:0] BR_GT   = 4'd4;
    localparam logic [3:0] BR_AL   = 4'd5;
    localparam logic [3:0] BR_CALL = 4'd6;
    localparam logic [3:0] BR_RET  = 4'd7;

    // Flag register layout is {C,Z,V,S} from bit 3 down to bit 0.
    localparam int FLG_S = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition decoder over the registered ALU flags.
// CALL/RET codes resolve as taken only when CALL_STACK_EN is defined.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] br_type,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (br_type)
            BR_Z:    cond_true = flags[FLG_Z];
            BR_C:    cond_true = flags[FLG_C];
            BR_NZNC: cond_true = ~flags[FLG_Z] & ~flags[FLG_C];
            BR_LT:   cond_true = flags[FLG_S] ^ flags[FLG_V];
            BR_GT:   cond_true = ~(flags[FLG_S] ^ flags[FLG_V]) & ~flags[FLG_Z];
            BR_AL:   cond_true = 1'b1;
`ifdef CALL_STACK_EN
            BR_CALL: cond_true = 1'b1;
            BR_RET:  cond_true = 1'b1;
`endif
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-stage PC sequencer: flag register, branch resolution, redirect/flush and halt.
// Define CALL_STACK_EN to add the RAS_DEPTH-entry return-address stack for CALL/RET.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter int              FLUSH_CYC = 2,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [3:0]      flags_in,
    input  logic            flags_we,
    input  logic            br_valid,
    input  logic [3:0]      br_type,
    input  logic [PC_W-1:0] br_target,
    output logic            br_ready,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            flush,
    output logic            taken_q,
    output logic            ras_err
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            halt_pend_q, halt_pend_d;
    logic            taken_d;
    logic            cond_true;
    logic            br_take;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] redirect_pc;

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .br_type   (br_type),
        .cond_true (cond_true)
    );

    assign pc_inc   = pc_q + PC_W'(1);
    assign br_ready = (state_q == ST_RUN) & ~stall;
    // A pending halt request pre-empts any branch offered in the same cycle.
    assign br_take  = br_ready & br_valid & cond_true & ~halt_req;
    assign pc       = pc_q;
    assign fetch_en = (state_q == ST_RUN);
    assign flush    = (state_q == ST_REDIRECT);

`ifdef CALL_STACK_EN
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d, sp_next, sp_prev;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic             ras_push;
    logic             ras_err_q, ras_err_d;

    // Circular stack: when full, the slot at sp_q holds the oldest entry.
    assign sp_next = (sp_q == SP_W'(RAS_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
    assign sp_prev = (sp_q == '0) ? SP_W'(RAS_DEPTH - 1) : sp_q - SP_W'(1);

    always_comb begin
        sp_d        = sp_q;
        ras_cnt_d   = ras_cnt_q;
        ras_push    = 1'b0;
        ras_err_d   = 1'b0;
        redirect_pc = br_target;
        if (br_take && (br_type == BR_CALL)) begin
            ras_push = 1'b1;
            sp_d     = sp_next;
            if (ras_cnt_q == CNT_W'(RAS_DEPTH)) begin
                ras_err_d = 1'b1;
            end else begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (br_take && (br_type == BR_RET)) begin
            if (ras_cnt_q == '0) begin
                ras_err_d = 1'b1;
            end else begin
                redirect_pc = ras_mem[sp_prev];
                sp_d        = sp_prev;
                ras_cnt_d   = ras_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q      <= '0;
            ras_cnt_q <= '0;
            ras_err_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            ras_cnt_q <= ras_cnt_d;
            ras_err_q <= ras_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[sp_q] <= pc_inc;
        end
    end

    assign ras_err = ras_err_q;
`else
    logic unused_ras_cfg;

    assign redirect_pc    = br_target;
    assign ras_err        = 1'b0;
    assign unused_ras_cfg = (RAS_DEPTH > 0);
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        taken_d     = 1'b0;
        flags_d     = flags_we ? flags_in : flags_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (br_take) begin
                    pc_d    = redirect_pc;
                    taken_d = 1'b1;
                    cnt_d   = 3'(FLUSH_CYC - 1);
                    state_d = ST_REDIRECT;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            ST_REDIRECT: begin
                // The flush always runs to completion; a halt seen meanwhile is deferred.
                if (cnt_q == '0) begin
                    state_d     = (halt_pend_q | halt_req) ? ST_HALT : ST_RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q - 3'd1;
                    halt_pend_d = halt_pend_q | halt_req;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_VEC;
            flags_q     <= '0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            taken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            taken_q     <= taken_d;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomised scoreboard bench for branch_sequencer against a behavioural sequencer model.
module tb_branch_sequencer;

    localparam int PC_W      = 8;
    localparam int FLUSH_CYC = 2;
    localparam int RAS_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst, stall, flags_we, br_valid, halt_req, resume;
    logic [3:0]      flags_in, br_type;
    logic [PC_W-1:0] br_target;
    logic            br_ready, fetch_en, flush, taken_q, ras_err;
    logic [PC_W-1:0] pc;

    always #5 clk = ~clk;

    branch_sequencer #(
        .PC_W      (PC_W),
        .RESET_VEC (8'h00),
        .FLUSH_CYC (FLUSH_CYC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flags_in  (flags_in),
        .flags_we  (flags_we),
        .br_valid  (br_valid),
        .br_type   (br_type),
        .br_target (br_target),
        .br_ready  (br_ready),
        .halt_req  (halt_req),
        .resume    (resume),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .taken_q   (taken_q),
        .ras_err   (ras_err)
    );

    typedef struct {
        logic [7:0] pc;
        logic       fe;
        logic       fl;
        logic       tk;
        logic       re;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: remaining flush cycles, halted flag, return addresses as a queue.
    int       m_pc;
    bit [3:0] m_flags;
    int       m_flush_left;
    bit       m_halted, m_halt_pend, m_taken, m_err, m_known;
    int       m_stack[$];

    function automatic bit cond_of(bit [3:0] f, bit [3:0] t);
        bit c, z, v, s;
        c = f[3]; z = f[2]; v = f[1]; s = f[0];
        case (t)
            4'd0: return z;
            4'd1: return c;
            4'd2: return !z && !c;
            4'd3: return s != v;
            4'd4: return (s == v) && !z;
            4'd5: return 1'b1;
`ifdef CALL_STACK_EN
            4'd6: return 1'b1;
            4'd7: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(bit r, bit st, bit fwe, bit [3:0] fin, bit bv,
                              bit [3:0] bt, bit [7:0] tgt, bit hr, bit rs);
        int tgt_pc;
        if (r) begin
            m_pc = 0; m_flags = 4'd0; m_flush_left = 0; m_halted = 0;
            m_halt_pend = 0; m_taken = 0; m_err = 0; m_known = 1;
            m_stack.delete();
            return;
        end
        if (!m_known) return;
        m_taken = 0;
        m_err   = 0;
        if (m_flush_left > 0) begin
            if (hr) m_halt_pend = 1;
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_halted    = m_halt_pend;
                m_halt_pend = 0;
            end
        end else if (m_halted) begin
            if (rs) m_halted = 0;
        end else if (hr) begin
            m_halted = 1;
        end else if (!st) begin
            if (bv && cond_of(m_flags, bt)) begin
                tgt_pc = int'(tgt);
`ifdef CALL_STACK_EN
                if (bt == 4'd6) begin
                    m_stack.push_back((m_pc + 1) % (1 << PC_W));
                    if (m_stack.size() > RAS_DEPTH) begin
                        void'(m_stack.pop_front());
                        m_err = 1;
                    end
                end else if (bt == 4'd7) begin
                    if (m_stack.size() == 0) m_err = 1;
                    else tgt_pc = m_stack.pop_back();
                end
`endif
                m_pc         = tgt_pc;
                m_taken      = 1;
                m_flush_left = FLUSH_CYC;
            end else begin
                m_pc = (m_pc + 1) % (1 << PC_W);
            end
        end
        if (fwe) m_flags = fin;
    endtask

    task automatic cyc(bit r, bit st, bit fwe, bit [3:0] fin, bit bv,
                       bit [3:0] bt, bit [7:0] tgt, bit hr, bit rs);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r; stall = st; flags_we = fwe; flags_in = fin; br_valid = bv;
        br_type = bt; br_target = tgt; halt_req = hr; resume = rs;
        if (m_known) begin
            e.pc  = m_pc[7:0];
            e.fe  = !m_halted && (m_flush_left == 0);
            e.fl  = (m_flush_left > 0);
            e.tk  = m_taken;
            e.re  = m_err;
            e.rdy = e.fe && !st;
            sb_q.push_back(e);
        end
        model_step(r, st, fwe, fin, bv, bt, tgt, hr, rs);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 0, 0);
    endtask

    task automatic branch(bit [3:0] bt, bit [7:0] tgt);
        cyc(0, 0, 0, 4'd0, 1, bt, tgt, 0, 0);
        repeat (FLUSH_CYC) idle();
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc",       pc,              e.pc);
            chk("fetch_en", 8'(fetch_en),    8'(e.fe));
            chk("flush",    8'(flush),       8'(e.fl));
            chk("taken_q",  8'(taken_q),     8'(e.tk));
            chk("ras_err",  8'(ras_err),     8'(e.re));
            chk("br_ready", 8'(br_ready),    8'(e.rdy));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit       r_rst, r_st, r_fwe, r_bv, r_hr, r_rs;
    bit [3:0] r_fin, r_bt;
    bit [7:0] r_tgt;

    initial begin
        rst = 1'b1; stall = 1'b0; flags_we = 1'b0; flags_in = 4'd0; br_valid = 1'b0;
        br_type = 4'd0; br_target = 8'h00; halt_req = 1'b0; resume = 1'b0;
        m_known = 0;

        cyc(1, 0, 0, 4'd0, 0, 4'd0, 8'h00, 0, 0);
        cyc(1, 0, 0, 4'd0, 0, 4'd0, 8'h00, 0, 0);
        repeat (4) idle();

        // Z flag set, then a Z-conditional branch to 0x40.
        cyc(0, 0, 1, 4'b0100, 0, 4'd0, 8'h00, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd0, 8'h40, 0, 0);
        repeat (3) idle();

        // Jump to 0x10 and load S=1,V=0 while flushing; GT not taken, LT taken.
        cyc(0, 0, 0, 4'd0, 1, 4'd5, 8'h10, 0, 0);
        cyc(0, 0, 1, 4'b0001, 0, 4'd0, 8'h00, 0, 0);
        idle();
        cyc(0, 0, 0, 4'd0, 1, 4'd4, 8'h80, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd3, 8'h30, 0, 0);
        repeat (3) idle();

        // Stalled branch request, accepted once stall drops.
        repeat (3) cyc(0, 1, 0, 4'd0, 1, 4'd5, 8'h60, 0, 0);
        cyc(0, 0, 0, 4'd0, 1, 4'd5, 8'h60, 0, 0);
        repeat (3) idle();

        // PC wrap from 0xFF.
        branch(4'd5, 8'hFF);
        repeat (3) idle();

        // Halt requested during flush, then resume.
        cyc(0, 0, 0, 4'd0, 1, 4'd5, 8'h22, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 1, 0);
        repeat (3) idle();
        cyc(0, 0, 0, 4'd0, 0, 4'd0, 8'h00, 0, 1);
        repeat (3) idle();

        // Reset in the middle of a flush.
        cyc(0, 0, 0, 4'd0, 1, 4'd5, 8'h99, 0, 0);
        cyc(1, 0, 0, 4'd0, 0, 4'd0, 8'h00, 0, 0);
        repeat (2) idle();

`ifdef CALL_STACK_EN
        branch(4'd5, 8'h20);
        branch(4'd6, 8'h50);
        branch(4'd7, 8'h00);
        idle();
        for (int k = 0; k < 5; k++) branch(4'd6, 8'(8'h50 + k));
        for (int k = 0; k < 5; k++) branch(4'd7, 8'h77);
        repeat (2) idle();
`else
        branch(4'd6, 8'h50);
        branch(4'd7, 8'h51);
        idle();
`endif

        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_fwe = ($urandom_range(0, 2) == 0);
            r_fin = 4'($urandom_range(0, 15));
            r_bv  = ($urandom_range(0, 1) == 0);
            r_bt  = 4'($urandom_range(0, 11));
            r_tgt = 8'($urandom_range(0, 255));
            r_hr  = ($urandom_range(0, 24) == 0);
            r_rs  = ($urandom_range(0, 4) == 0);
            cyc(r_rst, r_st, r_fwe, r_fin, r_bv, r_bt, r_tgt, r_hr, r_rs);
        end
        repeat (3) idle();

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
